// File: rtl/pico_sim.sv
// PicoBus register slave for the M503 QDRII traffic-generator system.
// Drives the global QDRII reset and exposes cal, error and capture data.
module pico_sim #(
  parameter logic [31:0] BASE_ADDR = 32'h12350000,
  parameter int          NUM_QDRII = 3,
  parameter logic [31:0] SIGNATURE = 32'h55AA55AA
) (
  input  logic                      PicoClk,
  input  logic                      PicoRst,
  input  logic [31:0]               PicoAddr,
  input  logic [127:0]              PicoDataIn,
  input  logic                      PicoWr,
  input  logic                      PicoRd,
  output logic [127:0]              PicoDataOut,
  output logic                      qdr_rst,
  input  logic [16*NUM_QDRII-1:0]   cal_done,
  input  logic [16*NUM_QDRII-1:0]   err_flags,
  input  logic [128*NUM_QDRII-1:0]  rd_data,
  input  logic [NUM_QDRII-1:0]      rd_data_valid
);

  localparam int CW = 16 * NUM_QDRII;

  localparam logic [31:0] CTRL_A = BASE_ADDR;
  localparam logic [31:0] SIG_A  = BASE_ADDR + 32'h10;
  localparam logic [31:0] ERR_A  = BASE_ADDR + 32'h20;
  localparam logic [31:0] DATA_A = BASE_ADDR + 32'h40;

  logic          rst_bit;
  logic [CW-1:0] err_q;
  logic [127:0]  data_q [NUM_QDRII];
  logic [127:0]  rd_val;

  always_ff @(posedge PicoClk) begin
    if (PicoRst)
      rst_bit <= 1'b0;
    else if (PicoWr && PicoAddr == CTRL_A)
      rst_bit <= PicoDataIn[64];
  end

  assign qdr_rst = rst_bit;

  // clear takes priority over a same-cycle error pulse
  always_ff @(posedge PicoClk) begin
    if (PicoRst || rst_bit)
      err_q <= '0;
    else
      err_q <= err_q | err_flags;
  end

  always_ff @(posedge PicoClk) begin
    for (int i = 0; i < NUM_QDRII; i++) begin
      if (PicoRst)
        data_q[i] <= '0;
      else if (rd_data_valid[i])
        data_q[i] <= rd_data[128*i +: 128];
    end
  end

  always_comb begin
    rd_val = '0;
    if (PicoAddr == CTRL_A) begin
      rd_val[CW-1:0] = cal_done;
      rd_val[64]     = rst_bit;
    end else if (PicoAddr == SIG_A) begin
      rd_val[31:0] = SIGNATURE;
    end else if (PicoAddr == ERR_A) begin
      rd_val[CW-1:0] = err_q;
    end else begin
      for (int i = 0; i < NUM_QDRII; i++) begin
        if (PicoAddr == DATA_A + 32'(i) * 32'h20)
          rd_val = data_q[i];
      end
    end
  end

  always_ff @(posedge PicoClk) begin
    if (PicoRst)
      PicoDataOut <= '0;
    else if (PicoRd)
      PicoDataOut <= rd_val;
    else
      PicoDataOut <= '0;
  end

endmodule

// File: tb/tb_pico_sim.sv
// Directed bench for pico_sim: one table row per clock cycle,
// inputs held for that cycle, outputs checked just after the edge.
module tb_pico_sim;

  localparam logic [31:0] B = 32'h12350000;

  logic         PicoClk = 1'b0;
  logic         PicoRst;
  logic [31:0]  PicoAddr;
  logic [127:0] PicoDataIn;
  logic         PicoWr;
  logic         PicoRd;
  logic [127:0] PicoDataOut;
  logic         qdr_rst;
  logic [47:0]  cal_done;
  logic [47:0]  err_flags;
  logic [383:0] rd_data;
  logic [2:0]   rd_data_valid;

  always #5 PicoClk = ~PicoClk;

  pico_sim dut (
    .PicoClk      (PicoClk),
    .PicoRst      (PicoRst),
    .PicoAddr     (PicoAddr),
    .PicoDataIn   (PicoDataIn),
    .PicoWr       (PicoWr),
    .PicoRd       (PicoRd),
    .PicoDataOut  (PicoDataOut),
    .qdr_rst      (qdr_rst),
    .cal_done     (cal_done),
    .err_flags    (err_flags),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid)
  );

  typedef struct {
    string        name;
    logic         rst;
    logic         wr;
    logic         rd;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [47:0]  cal;
    logic [47:0]  errf;
    logic [127:0] rdd;
    logic [2:0]   vld;
    logic [127:0] exp_out;
    logic         exp_rst;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t V(string name, logic rst, logic wr, logic rd,
                             logic [31:0] addr, logic [127:0] wdata,
                             logic [47:0] cal, logic [47:0] errf,
                             logic [127:0] rdd, logic [2:0] vld,
                             logic [127:0] exp_out, logic exp_rst);
    vec_t v;
    v.name = name; v.rst = rst; v.wr = wr; v.rd = rd;
    v.addr = addr; v.wdata = wdata; v.cal = cal; v.errf = errf;
    v.rdd = rdd; v.vld = vld; v.exp_out = exp_out; v.exp_rst = exp_rst;
    return v;
  endfunction

  localparam logic [127:0] RB = 128'h1 << 64;
  localparam logic [47:0]  C1 = 48'h0001_0001_0000;
  localparam logic [47:0]  C2 = 48'h0001_0001_0001;

  task automatic apply(input vec_t v);
    PicoRst       = v.rst;
    PicoWr        = v.wr;
    PicoRd        = v.rd;
    PicoAddr      = v.addr;
    PicoDataIn    = v.wdata;
    cal_done      = v.cal;
    err_flags     = v.errf;
    rd_data       = {3{v.rdd}};
    rd_data_valid = v.vld;
    @(posedge PicoClk);
    #1;
    n_vec++;
    if (PicoDataOut !== v.exp_out || qdr_rst !== v.exp_rst) begin
      n_err++;
      $display("FAIL %s: out=%h qdr_rst=%b, required out=%h qdr_rst=%b",
               v.name, PicoDataOut, qdr_rst, v.exp_out, v.exp_rst);
    end
  endtask

  initial begin
    // reset, basic reads, reset control
    tv.push_back(V("reset0",  1,0,0, B,       0,    0,  0, 0, 0, 0, 0));
    tv.push_back(V("reset1",  1,0,0, B,       0,    0,  0, 0, 0, 0, 0));
    tv.push_back(V("rd_err0", 0,0,1, B+'h20,  0,    0,  0, 0, 0, 0, 0));
    tv.push_back(V("rd_sig",  0,0,1, B+'h10,  0,    0,  0, 0, 0, 128'h55AA55AA, 0));
    tv.push_back(V("idle0",   0,0,0, B+'h10,  0,    0,  0, 0, 0, 0, 0));
    tv.push_back(V("wr_rst1", 0,1,0, B,       RB,   0,  0, 0, 0, 0, 1));
    tv.push_back(V("rd_ctl1", 0,0,1, B,       0,    0,  0, 0, 0, RB, 1));
    tv.push_back(V("wr_rst0", 0,1,0, B,       0,    0,  0, 0, 0, 0, 0));
    // calibration poll
    tv.push_back(V("cal_a",   0,0,1, B,       0,    C1, 0, 0, 0, 128'(C1), 0));
    tv.push_back(V("cal_b",   0,0,1, B,       0,    C2, 0, 0, 0, 128'(C2), 0));
    tv.push_back(V("cal_idle",0,0,0, B,       0,    C2, 0, 0, 0, 0, 0));
    // sticky errors, clear wins over set
    tv.push_back(V("err_pls", 0,0,0, B+'h20,  0,    0, 48'h10000, 0, 0, 0, 0));
    tv.push_back(V("err_rd1", 0,0,1, B+'h20,  0,    0,  0, 0, 0, 128'h10000, 0));
    tv.push_back(V("err_rd2", 0,0,1, B+'h20,  0,    0,  0, 0, 0, 128'h10000, 0));
    tv.push_back(V("err_clr1",0,1,0, B,       RB,   0,  0, 0, 0, 0, 1));
    tv.push_back(V("err_clr0",0,1,0, B,       0,    0, 48'h1, 0, 0, 0, 0));
    tv.push_back(V("err_rd0", 0,0,1, B+'h20,  0,    0,  0, 0, 0, 0, 0));
    // data capture, back-to-back reads
    tv.push_back(V("cap2",    0,0,0, B,       0,    0,  0, 128'hDEADBEEF, 3'b100, 0, 0));
    tv.push_back(V("rd_d2",   0,0,1, B+'h80,  0,    0,  0, 0, 0, 128'hDEADBEEF, 0));
    tv.push_back(V("rd_d0",   0,0,1, B+'h40,  0,    0,  0, 0, 0, 0, 0));
    tv.push_back(V("rd_d1",   0,0,1, B+'h60,  0,    0,  0, 0, 0, 0, 0));
    tv.push_back(V("rd_unmap",0,0,1, B+'h100, 0,    0,  0, 0, 0, 0, 0));
    tv.push_back(V("rd_alias",0,0,1, 32'h22350010, 0, 0, 0, 0, 0, 0, 0));
    // writes elsewhere are ignored
    tv.push_back(V("wr_err",  0,1,0, B+'h20,  '1,   0,  0, 0, 0, 0, 0));
    tv.push_back(V("rd_err_w",0,0,1, B+'h20,  0,    0,  0, 0, 0, 0, 0));
    // simultaneous read/write of CTRL returns pre-write value
    tv.push_back(V("rw_ctl1", 0,1,1, B,       RB,   0,  0, 0, 0, 0, 1));
    tv.push_back(V("rw_ctl0", 0,1,1, B,       0,    0,  0, 0, 0, RB, 0));
    tv.push_back(V("cap0",    0,0,0, B,       0,    0,  0, 128'hCAFE, 3'b001, 0, 0));
    tv.push_back(V("rd_d0b",  0,0,1, B+'h40,  0,    0,  0, 0, 0, 128'hCAFE, 0));
    tv.push_back(V("rd_d2b",  0,0,1, B+'h80,  0,    0,  0, 0, 0, 128'hDEADBEEF, 0));
    tv.push_back(V("after",   0,0,0, B+'h80,  0,    0,  0, 0, 0, 0, 0));

    foreach (tv[i]) apply(tv[i]);

    // mid-run reset: read in flight discarded, all state cleared
    apply(V("pre_rst",   0,1,0, B,      RB, 0, 48'hFF, 128'h5555, 3'b111, 0, 1));
    apply(V("rst_rd",    1,0,1, B+'h10, 0,  0, 0, 0, 0, 0, 0));
    apply(V("post_sig",  0,0,1, B+'h10, 0,  0, 0, 0, 0, 128'h55AA55AA, 0));
    apply(V("post_d2",   0,0,1, B+'h80, 0,  0, 0, 0, 0, 0, 0));
    apply(V("post_d0",   0,0,1, B+'h40, 0,  0, 0, 0, 0, 0, 0));
    apply(V("post_err",  0,0,1, B+'h20, 0,  0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
